// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter sharing one 4-bit add/sub/and/or alu; IDLE -> EXEC -> RESP per op.
// Optional per-port grant counters when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
`ifdef ALU_ARB_STATS_EN
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1,
`endif
  output logic             busy
);

  if (WIDTH != 4 || CNT_W == 0) begin : g_bad_param
    $error("alu_arbiter: WIDTH must be 4 and CNT_W must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } alu_req_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  state_t           state, next_state;
  logic             rr_ptr, owner, winner, accept;
  alu_req_t         cap, sel_req;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [3:0]       alu_flags;

  // Winner is the only valid port, or the round-robin pointer when both are valid
  always_comb begin
    next_state = state;
    winner     = rr_ptr;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (req0_valid && !req1_valid) winner = 1'b0;
    else if (!req0_valid && req1_valid) winner = 1'b1;
    case (state)
      IDLE: begin
        if ((req0_valid || req1_valid) && !rst) begin
          accept     = 1'b1;
          req0_ready = !winner;
          req1_ready = winner;
          next_state = EXEC;
        end
      end
      EXEC:    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign sel_req = winner ? '{op: req1_op, a: req1_a, b: req1_b}
                          : '{op: req0_op, a: req0_a, b: req0_b};

  // Alu on captured operands; sub borrow shows up as the extra top bit of the wide difference
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (cap.op)
      OP_ADD: begin
        sum     = {1'b0, cap.a} + {1'b0, cap.b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (cap.a[WIDTH-1] == cap.b[WIDTH-1]) && (alu_res[WIDTH-1] != cap.a[WIDTH-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, cap.a} - {1'b0, cap.b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (cap.a[WIDTH-1] != cap.b[WIDTH-1]) && (alu_res[WIDTH-1] != cap.a[WIDTH-1]);
      end
      OP_AND:  alu_res = cap.a & cap.b;
      OP_OR:   alu_res = cap.a | cap.b;
      default: alu_res = '0;
    endcase
  end

  assign alu_flags = {alu_v, alu_res[WIDTH-1], (alu_res == '0), alu_c};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
    end
  end

  // Capture on accept, register alu output at end of EXEC, hand back pointer after RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      cap        <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      rsp0_valid <= (state == EXEC) && !owner;
      rsp1_valid <= (state == EXEC) && owner;
      if (accept) begin
        cap   <= sel_req;
        owner <= winner;
      end
      if (state == EXEC) begin
        rsp_result <= alu_res;
        rsp_flags  <= alu_flags;
      end
      if (state == RESP) rr_ptr <= ~owner;
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating grant counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (req0_ready && (gnt_cnt0 != '1)) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
      if (req1_ready && (gnt_cnt1 != '1)) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule
